// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: framed byte-stream loader for the accumulator CPU's program RAM.
// Holds the CPU in reset while a frame is loading and releases it only after
// the frame is accepted. Optional trailing checksum byte: define LOADER_CSUM_EN.
module prog_loader #(
    parameter int           ADDR_W = 4,
    parameter int           DATA_W = 8,
    parameter logic [3:0]   MAGIC  = 4'hA
) (
    input  logic              clk,
    input  logic              pc_reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] load_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Length field of 0 stands for a full RAM image.
    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
`ifdef LOADER_CSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W:0]   rem;     // data bytes still expected in this frame
    logic              xfer;
    logic [3:0]        hdr_magic;
    logic [ADDR_W-1:0] hdr_len;

    assign xfer      = in_valid && in_ready;
    assign hdr_magic = in_data[DATA_W-1 -: 4];
    assign hdr_len   = in_data[ADDR_W-1:0];

`ifdef LOADER_CSUM_EN
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] csum_nxt;
    assign csum_nxt = csum + in_data;
`endif

    // Frame FSM; every output is registered and updated alongside the state.
    always_ff @(posedge clk or posedge pc_reset) begin
        if (pc_reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            load_we   <= 1'b0;
            load_addr <= '0;
            load_data <= '0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            idx       <= '0;
            rem       <= '0;
`ifdef LOADER_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            load_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    // in_valid is ignored here, so start always wins.
                    if (start) begin
                        state    <= ST_HDR;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        idx      <= '0;
`ifdef LOADER_CSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        if (hdr_magic != MAGIC) begin
                            state    <= ST_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= ST_DATA;
                            rem   <= (hdr_len == '0) ? LEN_MAX : {1'b0, hdr_len};
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        load_we   <= 1'b1;
                        load_addr <= idx;
                        load_data <= in_data;
                        idx       <= idx + 1'b1;
                        rem       <= rem - 1'b1;
`ifdef LOADER_CSUM_EN
                        csum      <= csum_nxt;
                        if (rem == 1) state <= ST_CSUM;
`else
                        // Without a checksum the last data byte completes the frame.
                        if (rem == 1) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end
`endif
                    end
                end
`ifdef LOADER_CSUM_EN
                ST_CSUM: begin
                    // Accepted when data bytes plus checksum byte sum to zero.
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (csum_nxt == '0) begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;

`ifdef LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       pc_reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       load_we;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk       (clk),
        .pc_reset  (pc_reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: what a frame should do, derived from the frame rules directly.
    // n = bytes the loader will consume, ok = frame accepted.
    function automatic void model(input bq_t f, output int n, output int len,
                                  output bit hdr_ok, output bit ok);
        int s;
        logic [7:0] h;
        h      = f[0];
        hdr_ok = (h[7:4] == 4'hA);
        len    = (h[3:0] == 4'd0) ? 16 : int'(h[3:0]);
        if (!hdr_ok) begin
            n  = 1;
            ok = 1'b0;
        end else if (CSUM_EN) begin
            s = 0;
            for (int k = 1; k <= len + 1; k++) s += int'(f[k]);
            ok = ((s % 256) == 0);
            n  = len + 2;
        end else begin
            ok = 1'b1;
            n  = len + 1;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_load_we"}, load_we, 0);
        chk({tag, "_load_addr"}, load_addr, 0);
        chk({tag, "_load_data"}, load_data, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Start pulse issued together with in_valid: start must win, nothing consumed.
    task automatic kick();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
        chk("start_done", done, 0);
        chk("start_err", err, 0);
        chk("start_hold", cpu_hold, 1);
        chk("start_we", load_we, 0);
    endtask

    // Stream a frame with random valid gaps and spurious start pulses, checking
    // each RAM write one cycle after its transfer and the final outcome.
    task automatic run_frame(input bq_t f, input int gap_pct);
        int  n, len, i, cyc, prev;
        bit  hdr_ok, ok, v, x;
        model(f, n, len, hdr_ok, ok);
        kick();
        i = 0; cyc = 0; prev = -1;
        while (i < n && cyc < 400) begin
            @(negedge clk);
            if (prev >= 1) begin
                chk("wr_we", load_we, 1);
                chk("wr_addr", load_addr, (prev - 1) % 16);
                chk("wr_data", load_data, f[prev]);
            end else begin
                chk("no_wr", load_we, 0);
            end
            v        = ($urandom_range(99) >= gap_pct);
            in_valid = v;
            in_data  = v ? f[i] : 8'($urandom);
            start    = ($urandom_range(15) == 0);
            x        = v && in_ready;
            @(posedge clk);
            prev = (x && hdr_ok && i >= 1 && i <= len) ? i : -1;
            if (x) i++;
            cyc++;
        end
        if (i < n) chk("timeout", i, n);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        if (prev >= 1) begin
            chk("wr_we", load_we, 1);
            chk("wr_addr", load_addr, (prev - 1) % 16);
            chk("wr_data", load_data, f[prev]);
        end else begin
            chk("no_wr", load_we, 0);
        end
        chk("end_busy", busy, 0);
        chk("end_ready", in_ready, 0);
        chk("end_done", done, ok);
        chk("end_err", err, !ok);
        chk("end_hold", cpu_hold, !ok);
        // Extra bytes after the frame must be refused.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("post_we", load_we, 0);
            chk("post_ready", in_ready, 0);
            chk("post_done", done, ok);
        end
        in_valid = 1'b0;
    endtask

    function automatic bq_t rand_frame();
        bq_t f;
        int  len, s;
        logic [3:0] nib;
        nib = 4'($urandom);
        len = (nib == 4'd0) ? 16 : int'(nib);
        f.push_back(($urandom_range(7) == 0) ? {4'h5, nib} : {4'hA, nib});
        s = 0;
        for (int k = 0; k < len; k++) begin
            f.push_back(8'($urandom));
            s += int'(f[k + 1]);
        end
        if ($urandom_range(3) == 0) f.push_back(8'($urandom));
        else                        f.push_back(8'((256 - (s % 256)) % 256));
        return f;
    endfunction

    initial begin
        bq_t f;
        pc_reset = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        pc_reset = 1'b0;

        // Basic frame
        f = {8'hA3, 8'h11, 8'h22, 8'h33, 8'h9A};
        run_frame(f, 0);

        // Reset while idle (after DONE) restores everything
        @(negedge clk);
        pc_reset = 1'b1;
        #1;
        check_reset_outputs("rst_idle");
        @(negedge clk);
        pc_reset = 1'b0;

        // Bad checksum (accepted when no checksum is carried)
        f = {8'hA2, 8'h01, 8'h02, 8'h00};
        run_frame(f, 30);

        // Full 16-byte image
        f = {8'hA0};
        for (int k = 0; k < 16; k++) f.push_back(8'(k));
        f.push_back(8'h88);
        run_frame(f, 0);

        // Magic mismatch
        f = {8'h53, 8'h01, 8'h02};
        run_frame(f, 0);

        // Randomized frames
        for (int t = 0; t < 12; t++) begin
            f = rand_frame();
            run_frame(f, $urandom_range(60));
        end

        // Gaps then reset mid-DATA
        kick();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hA1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            chk("gap_ready", in_ready, 1);
            chk("gap_busy", busy, 1);
            chk("gap_we", load_we, 0);
        end
        #2;
        pc_reset = 1'b1;
        #1;
        chk("mid_ready", in_ready, 0);
        chk("mid_busy", busy, 0);
        chk("mid_hold", cpu_hold, 1);
        chk("mid_we", load_we, 0);
        chk("mid_done", done, 0);
        chk("mid_err", err, 0);
        @(negedge clk);
        pc_reset = 1'b0;
        f = {8'hA4, 8'h10, 8'h20, 8'h30, 8'h40, 8'h60};
        run_frame(f, 20);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
